// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer
// Queues LOAD / SHL-by-N / SHR-by-N / NOP commands from a valid/ready port.
// Each command is replayed as one-per-clock strobes on ld/sl/sr/d_in for the
// 4-bit shift stage. done pulses once for every retired command.
//
// Configuration macro: SHIFT_SEQ_FIFO_EN
//   defined   : FIFO_DEPTH-entry command FIFO in front of the FSM.
//   undefined : no FIFO. Commands load straight into the FSM, cmd_ready is
//               high only in IDLE, and level is tied to 0.
//
// Ports
//   clk, reset        clock (rising edge), async active-low reset
//   cmd_valid/ready   command handshake (cmd_ready is combinational)
//   cmd_op            00 NOP, 01 LOAD, 10 SHL, 11 SHR
//   cmd_arg           LOAD data or shift count
//   ld, sl, sr        single-cycle strobes to the shift stage
//   d_in              load data, valid while ld=1, else 0
//   busy              FSM not IDLE or FIFO non-empty
//   done              one-cycle pulse per retired command
//   level             FIFO occupancy
module shift_cmd_sequencer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DATA_W     = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [1:0]                  cmd_op,
   input  logic [DATA_W-1:0]           cmd_arg,
   output logic                        ld,
   output logic                        sl,
   output logic                        sr,
   output logic [DATA_W-1:0]           d_in,
   output logic                        busy,
   output logic                        done,
   output logic [$clog2(FIFO_DEPTH):0] level
);

   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_SHL  = 2'b10;
   localparam logic [1:0] OP_SHR  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_EXEC   = 2'b01,
      S_RETIRE = 2'b10
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] cnt;
   logic              pend_done;

   // Command source seen by the FSM: FIFO head, or the input port directly
   logic              src_valid;
   logic [1:0]        src_op;
   logic [DATA_W-1:0] src_arg;
   logic [LVL_W-1:0]  level_nxt;

   logic              can_take;
   logic              take;
   logic              src_zero;
   logic              idle_nxt;

`ifdef SHIFT_SEQ_FIFO_EN
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [1:0]        mem_op  [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_arg [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push;

   assign cmd_ready = (level != LVL_W'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign src_valid = (level != '0);
   assign src_op    = mem_op[rd_ptr];
   assign src_arg   = mem_arg[rd_ptr];

   // Occupancy after this edge; push+pop together leaves it unchanged
   always_comb begin
      level_nxt = level;
      if (push && !take) begin
         level_nxt = level + LVL_W'(1);
      end else if (!push && take) begin
         level_nxt = level - LVL_W'(1);
      end
   end

   // Pointers and occupancy; depth is a power of two so pointers wrap freely
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (take) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         level <= level_nxt;
      end
   end

   // Storage needs no reset: entries are only read when level says so
   always_ff @(posedge clk) begin
      if (push) begin
         mem_op[wr_ptr]  <= cmd_op;
         mem_arg[wr_ptr] <= cmd_arg;
      end
   end
`else
   assign cmd_ready = (state == S_IDLE);
   assign src_valid = cmd_valid && cmd_ready;
   assign src_op    = cmd_op;
   assign src_arg   = cmd_arg;
   assign level     = '0;
   assign level_nxt = '0;
`endif

   // The FSM can accept a command from IDLE, RETIRE, or on the last strobe
   assign can_take = (state == S_IDLE) || (state == S_RETIRE) ||
                     ((state == S_EXEC) && (cnt == DATA_W'(1)));
   assign take     = can_take && src_valid;
   assign src_zero = (src_op == OP_NOP) ||
                     ((src_op != OP_LOAD) && (src_arg == '0));
   assign idle_nxt = !take && ((state == S_IDLE) || (state == S_RETIRE));

   // Sequencer FSM. The first strobe of a command is registered on the same
   // edge that pops it, so cnt counts strobes still to run including the
   // current one. Strobe-less commands park in RETIRE with pend_done set and
   // pulse done on the way out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         pend_done <= 1'b0;
         ld        <= 1'b0;
         sl        <= 1'b0;
         sr        <= 1'b0;
         d_in      <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         ld   <= 1'b0;
         sl   <= 1'b0;
         sr   <= 1'b0;
         d_in <= '0;
         done <= 1'b0;

         case (state)
            S_IDLE: begin
            end
            S_EXEC: begin
               if (cnt == DATA_W'(1)) begin
                  done <= 1'b1;
                  if (!take) begin
                     state <= S_RETIRE;
                  end
               end else begin
                  cnt  <= cnt - DATA_W'(1);
                  ld   <= ld;
                  sl   <= sl;
                  sr   <= sr;
                  d_in <= d_in;
               end
            end
            S_RETIRE: begin
               done      <= pend_done;
               pend_done <= 1'b0;
               if (!take) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         if (take) begin
            if (src_zero) begin
               state     <= S_RETIRE;
               pend_done <= 1'b1;
            end else begin
               state <= S_EXEC;
               case (src_op)
                  OP_LOAD: begin
                     cnt  <= DATA_W'(1);
                     ld   <= 1'b1;
                     d_in <= src_arg;
                  end
                  OP_SHL: begin
                     cnt <= src_arg;
                     sl  <= 1'b1;
                  end
                  OP_SHR: begin
                     cnt <= src_arg;
                     sr  <= 1'b1;
                  end
                  default: begin
                     cnt <= DATA_W'(1);
                  end
               endcase
            end
         end

         busy <= !(idle_nxt && (level_nxt == '0));
      end
   end

endmodule
